// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size codes
// and the request/response FSM state encoding.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one access: load extraction and extension, store lane
// shift, byte enables, and detection of misaligned or illegal size codes.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  func3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_data_o,
   output logic [3:0]  be_o,
   output logic        err_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s    = rword_i[{offset_i, 3'b000} +: 8];
   assign half_s    = offset_i[1] ? rword_i[31:16] : rword_i[15:0];
   assign st_data_o = wdata_i << {offset_i, 3'b000};

   // Size decode; unsigned codes are load-only, so a store using them is an error
   always_comb begin
      ld_data_o = 32'd0;
      be_o      = 4'b0000;
      err_o     = 1'b0;
      case (func3_i)
         F3_B: begin
            ld_data_o = {{24{byte_s[7]}}, byte_s};
            be_o      = 4'b0001 << offset_i;
         end
         F3_H: begin
            ld_data_o = {{16{half_s[15]}}, half_s};
            be_o      = 4'b0011 << offset_i;
            err_o     = offset_i[0];
         end
         F3_W: begin
            ld_data_o = rword_i;
            be_o      = 4'b1111;
            err_o     = (offset_i != 2'b00);
         end
         F3_BU: begin
            ld_data_o = {24'd0, byte_s};
            err_o     = we_i;
         end
         F3_HU: begin
            ld_data_o = {16'd0, half_s};
            err_o     = offset_i[0] | we_i;
         end
         default: begin
            err_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready load/store port with a fixed
// number of wait states and a response held until the requester takes it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [15:0] CNT_INIT    = (WAIT_CYCLES > 0) ? 16'(WAIT_CYCLES - 1) : 16'd0;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  func3_q;
   logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic        accept_s, access_s, in_range_s, lane_err_s, err_s;
   logic        op_we_s;
   logic [31:0] op_addr_s, op_wdata_s, rword_s, ld_data_s, st_data_s;
   logic [2:0]  op_func3_s;
   logic [3:0]  be_s;
   logic [AW-1:0] idx_s;

   assign accept_s   = req_ready_q & req_valid;
   assign in_range_s = ({1'b0, op_addr_s} < LIMIT_BYTES);
   assign idx_s      = op_addr_s[AW+1:2];
   assign rword_s    = in_range_s ? mem_q[idx_s] : 32'd0;
   assign err_s      = lane_err_s | ~in_range_s;

   // Zero-wait accesses happen on the accept edge, so they use the live request
   always_comb begin
      if (state_q == ST_IDLE) begin
         op_we_s    = req_we;
         op_addr_s  = req_addr;
         op_wdata_s = req_wdata;
         op_func3_s = req_func3;
      end else begin
         op_we_s    = we_q;
         op_addr_s  = addr_q;
         op_wdata_s = wdata_q;
         op_func3_s = func3_q;
      end
   end

   dmem_lane_align u_lane_align (
      .we_i      (op_we_s),
      .offset_i  (op_addr_s[1:0]),
      .func3_i   (op_func3_s),
      .wdata_i   (op_wdata_s),
      .rword_i   (rword_s),
      .ld_data_o (ld_data_s),
      .st_data_o (st_data_s),
      .be_o      (be_s),
      .err_o     (lane_err_s)
   );

   // State, counter, latched request and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 16'd0;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         func3_q      <= 3'b000;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         if (accept_s) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            func3_q <= req_func3;
         end
      end
   end

   // Next-state and wait counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && (WAIT_CYCLES == 0)) begin
               state_d = ST_RESP;
            end else if (accept_s) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // Output next values; the access is performed on the edge entering RESP
   always_comb begin
      access_s     = (state_d == ST_RESP) && (state_q != ST_RESP);
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
      if (access_s) begin
         resp_rdata_d = (err_s | op_we_s) ? 32'd0 : ld_data_s;
         resp_err_d   = err_s;
      end else begin
         resp_rdata_d = resp_rdata_q;
         resp_err_d   = resp_err_q;
      end
   end

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && access_s && op_we_s && !err_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem_q[idx_s][8*b +: 8] <= st_data_s[8*b +: 8];
            end
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at the default parameters.
module tb_dmem_responder;

   localparam int WAITS = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_func3;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int pass_cnt;
   int total_cnt;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_func3  (req_func3),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request and collect its response; called #1 after a rising edge.
   // lat counts rising edges from the accept edge to the first one after which resp_valid is high.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output logic err,
                         output int lat);
      int n;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_func3 = f3;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'hA5A5_A5A5;
      lat = 1;
      while (!resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rd  = resp_rdata;
      err = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", req_ready);
      else pass_cnt++;
      total_cnt++;
      if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
      else pass_cnt++;
      total_cnt++;
      if (resp_rdata !== 32'd0 || resp_err !== 1'b0)
         $display("FAIL reset_resp_data: got %h/%b expected 00000000/0", resp_rdata, resp_err);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", req_ready);
      else pass_cnt++;
   endtask

   task automatic test_word();
      logic [31:0] rd;
      logic        err;
      int          lat;
      do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'd0 || err !== 1'b0)
         $display("FAIL sw_resp: got %h/%b expected 00000000/0", rd, err);
      else pass_cnt++;
      do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h expected deadbeef", rd);
      else pass_cnt++;
      total_cnt++;
      if (err !== 1'b0) $display("FAIL lw_err: got %b expected 0", err);
      else pass_cnt++;
      total_cnt++;
      if (lat !== WAITS + 1) $display("FAIL lw_latency: got %0d expected %0d", lat, WAITS + 1);
      else pass_cnt++;
   endtask

   task automatic test_byte();
      logic [31:0] rd;
      logic        err;
      int          lat;
      do_req(1'b1, 32'h21, 32'h0000_0080, 3'b000, rd, err, lat);
      do_req(1'b0, 32'h21, 32'h0, 3'b000, rd, err, lat);
      total_cnt++;
      if (rd !== 32'hFFFF_FF80 || err !== 1'b0)
         $display("FAIL lb_sext: got %h/%b expected ffffff80/0", rd, err);
      else pass_cnt++;
      do_req(1'b0, 32'h21, 32'h0, 3'b100, rd, err, lat);
      total_cnt++;
      if (rd !== 32'h0000_0080) $display("FAIL lbu_zext: got %h expected 00000080", rd);
      else pass_cnt++;
      do_req(1'b0, 32'h20, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'h0000_8000) $display("FAIL sb_lane: got %h expected 00008000", rd);
      else pass_cnt++;
   endtask

   task automatic test_half();
      logic [31:0] rd;
      logic        err;
      int          lat;
      do_req(1'b1, 32'h32, 32'h0000_8001, 3'b001, rd, err, lat);
      do_req(1'b0, 32'h32, 32'h0, 3'b001, rd, err, lat);
      total_cnt++;
      if (rd !== 32'hFFFF_8001) $display("FAIL lh_sext: got %h expected ffff8001", rd);
      else pass_cnt++;
      do_req(1'b0, 32'h32, 32'h0, 3'b101, rd, err, lat);
      total_cnt++;
      if (rd !== 32'h0000_8001) $display("FAIL lhu_zext: got %h expected 00008001", rd);
      else pass_cnt++;
      do_req(1'b0, 32'h30, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'h8001_0000) $display("FAIL sh_lane: got %h expected 80010000", rd);
      else pass_cnt++;
      do_req(1'b0, 32'h31, 32'h0, 3'b001, rd, err, lat);
      total_cnt++;
      if (rd !== 32'd0 || err !== 1'b1)
         $display("FAIL lh_misaligned: got %h/%b expected 00000000/1", rd, err);
      else pass_cnt++;
   endtask

   task automatic test_misaligned_store();
      logic [31:0] rd;
      logic        err;
      int          lat;
      do_req(1'b1, 32'h40, 32'h1122_3344, 3'b010, rd, err, lat);
      do_req(1'b1, 32'h41, 32'hCAFE_F00D, 3'b010, rd, err, lat);
      total_cnt++;
      if (err !== 1'b1) $display("FAIL sw_misaligned_err: got %b expected 1", err);
      else pass_cnt++;
      do_req(1'b0, 32'h40, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'h1122_3344) $display("FAIL sw_misaligned_nowrite: got %h expected 11223344", rd);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        err;
      int          lat;
      do_req(1'b0, 32'h0000_1000, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'd0 || err !== 1'b1)
         $display("FAIL lw_out_of_range: got %h/%b expected 00000000/1", rd, err);
      else pass_cnt++;
      do_req(1'b1, 32'h0000_0FFC, 32'h7654_3210, 3'b010, rd, err, lat);
      do_req(1'b0, 32'h0000_0FFC, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'h7654_3210 || err !== 1'b0)
         $display("FAIL lw_last_word: got %h/%b expected 76543210/0", rd, err);
      else pass_cnt++;
      do_req(1'b0, 32'h10, 32'h0, 3'b011, rd, err, lat);
      total_cnt++;
      if (rd !== 32'd0 || err !== 1'b1)
         $display("FAIL illegal_func3: got %h/%b expected 00000000/1", rd, err);
      else pass_cnt++;
      do_req(1'b1, 32'h10, 32'h0000_00FF, 3'b100, rd, err, lat);
      total_cnt++;
      if (err !== 1'b1) $display("FAIL store_bu_err: got %b expected 1", err);
      else pass_cnt++;
      do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'hDEAD_BEEF) $display("FAIL store_bu_nowrite: got %h expected deadbeef", rd);
      else pass_cnt++;
   endtask

   task automatic test_back_pressure();
      int n;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h10;
      req_func3 = 3'b010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      // A new request presented while busy must be ignored
      req_valid = 1'b1;
      req_addr  = 32'h40;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if (resp_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b expected 1", i, resp_valid);
         else pass_cnt++;
         total_cnt++;
         if (resp_rdata !== 32'hDEAD_BEEF)
            $display("FAIL hold_rdata[%0d]: got %h expected deadbeef", i, resp_rdata);
         else pass_cnt++;
         total_cnt++;
         if (req_ready !== 1'b0) $display("FAIL hold_req_ready[%0d]: got %b expected 0", i, req_ready);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      total_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL after_handshake: got valid=%b ready=%b expected valid=0 ready=1",
                  resp_valid, req_ready);
      else pass_cnt++;
   endtask

   task automatic test_rst_mid_op();
      logic [31:0] rd;
      logic        err;
      int          lat;
      do_req(1'b1, 32'h50, 32'hAAAA_5555, 3'b010, rd, err, lat);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h50;
      req_wdata = 32'h1234_5678;
      req_func3 = 3'b010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0)
         $display("FAIL rst_mid_outputs: got valid=%b ready=%b expected valid=0 ready=0",
                  resp_valid, req_ready);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL rst_mid_idle: got %b expected 1", req_ready);
      else pass_cnt++;
      do_req(1'b0, 32'h50, 32'h0, 3'b010, rd, err, lat);
      total_cnt++;
      if (rd !== 32'hAAAA_5555) $display("FAIL rst_mid_dropped: got %h expected aaaa5555", rd);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_func3  = 3'b000;
      resp_ready = 1'b0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned_store();
      test_errors();
      test_back_pressure();
      test_rst_mid_op();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
